// File: rtl/regfile_writeback_if.sv
// MEM/WB boundary bundle: MEM-stage instruction fields in, register-file write port out.
interface regfile_writeback_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            stall;
  logic            flush;
  logic            mem_valid;
  logic            mem_reg_write;
  logic [AW-1:0]   mem_rd;
  logic [1:0]      mem_wb_sel;
  logic [2:0]      mem_funct3;
  logic [1:0]      mem_addr_lo;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_load_data;
  logic [XLEN-1:0] mem_pc_plus4;
  logic            we;
  logic [AW-1:0]   D_addr;
  logic [XLEN-1:0] Rin;
  logic            init_busy;

  modport master (
    output stall, flush, mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
           mem_funct3, mem_addr_lo, mem_alu_result, mem_load_data, mem_pc_plus4,
    input  we, D_addr, Rin, init_busy
  );

  modport slave (
    input  stall, flush, mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
           mem_funct3, mem_addr_lo, mem_alu_result, mem_load_data, mem_pc_plus4,
    output we, D_addr, Rin, init_busy
  );
endinterface

// File: rtl/regfile_writeback.sv
// MEM/WB register and writeback mux driving the register-file write port;
// clears every register after reset while holding init_busy.
module regfile_writeback #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_DEPTH = 32
) (
  input logic                clk,
  input logic                reset,
  regfile_writeback_if.slave wb
);
  localparam int unsigned AW = $clog2(REG_DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   cnt, cnt_n;
  logic            we_n;
  logic [AW-1:0]   addr_n;
  logic [XLEN-1:0] rin_n;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_data;

  // addr_lo[0] is deliberately ignored for halfwords; alignment is checked upstream
  always_comb begin
    lane_b = wb.mem_load_data[8*wb.mem_addr_lo +: 8];
    lane_h = wb.mem_addr_lo[1] ? wb.mem_load_data[16 +: 16] : wb.mem_load_data[0 +: 16];
    case (wb.mem_funct3)
      3'b000:  load_val = {{(XLEN-8){lane_b[7]}}, lane_b};
      3'b001:  load_val = {{(XLEN-16){lane_h[15]}}, lane_h};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, lane_b};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, lane_h};
      default: load_val = wb.mem_load_data;
    endcase
  end

  always_comb begin
    case (wb.mem_wb_sel)
      2'b01:   wb_data = load_val;
      2'b10:   wb_data = wb.mem_pc_plus4;
      default: wb_data = wb.mem_alu_result;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = 1'b0;
    addr_n  = wb.D_addr;
    rin_n   = wb.Rin;
    case (state)
      INIT: begin
        we_n   = 1'b1;
        addr_n = cnt;
        rin_n  = '0;
        cnt_n  = cnt + AW'(1);
        if (cnt == AW'(REG_DEPTH-1))
          state_n = RUN;
      end
      RUN: begin
        if (!wb.stall) begin
          we_n   = wb.mem_valid & wb.mem_reg_write & (wb.mem_rd != '0) & ~wb.flush;
          addr_n = wb.mem_rd;
          rin_n  = wb_data;
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      cnt       <= '0;
      wb.we     <= 1'b0;
      wb.D_addr <= '0;
      wb.Rin    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wb.we     <= we_n;
      wb.D_addr <= addr_n;
      wb.Rin    <= rin_n;
    end
  end

  always_comb wb.init_busy = (state == INIT);
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a behavioural register file on the write port.
module tb_regfile_writeback;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] rf [32];

  regfile_writeback_if #(.XLEN(32), .AW(5)) bus ();

  regfile_writeback #(.XLEN(32), .REG_DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.we) rf[bus.D_addr] <= bus.Rin;

  typedef struct {
    string       name;
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] alu;
    logic [31:0] load;
    logic [31:0] pc4;
    logic        exp_we;
    logic [31:0] exp_rin;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.flush = 1'b0; bus.mem_valid = 1'b0; bus.mem_reg_write = 1'b0;
    bus.mem_rd = '0; bus.mem_wb_sel = '0; bus.mem_funct3 = '0; bus.mem_addr_lo = '0;
    bus.mem_alu_result = '0; bus.mem_load_data = '0; bus.mem_pc_plus4 = '0;
  endtask

  task automatic present(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc4);
    bus.mem_valid = 1'b1; bus.mem_reg_write = 1'b1; bus.mem_rd = rd; bus.mem_wb_sel = sel;
    bus.mem_funct3 = f3; bus.mem_addr_lo = lo; bus.mem_alu_result = alu;
    bus.mem_load_data = ld; bus.mem_pc_plus4 = pc4;
  endtask

  task automatic check_clear_sequence(input string tag);
    int we_cycles = 0;
    for (int i = 0; i < 32; i++) begin
      edge_sample();
      if (bus.we === 1'b1) we_cycles++;
      check({tag, "_addr"}, 32'(bus.D_addr), 32'(i));
      check({tag, "_rin"}, bus.Rin, 32'h0);
      check({tag, "_busy"}, 32'(bus.init_busy), (i == 31) ? 32'h0 : 32'h1);
    end
    check({tag, "_we_cycles"}, 32'(we_cycles), 32'd32);
    edge_sample();
    check({tag, "_we_after"}, 32'(bus.we), 32'h0);
  endtask

  initial begin
    logic [31:0] held_rin;
    logic [4:0]  held_addr;
    for (int i = 0; i < 32; i++) rf[i] = 32'hDEAD_BEEF;
    idle_inputs();

    // Reset state, then full clear with idle inputs.
    #12;
    check("rst_we", 32'(bus.we), 32'h0);
    check("rst_addr", 32'(bus.D_addr), 32'h0);
    check("rst_rin", bus.Rin, 32'h0);
    check("rst_busy", 32'(bus.init_busy), 32'h1);
    @(negedge clk); reset = 1'b0;
    check_clear_sequence("init");
    for (int i = 0; i < 32; i++) check("clear_readback", rf[i], 32'h0);

    // Reset pulse mid-clear restarts from register 0; mem inputs must be ignored.
    @(negedge clk); reset = 1'b1;
    #2;
    @(negedge clk); reset = 1'b0;
    present(5'd7, 2'b00, 3'b010, 2'b00, 32'hFFFF_FFFF, 32'h0, 32'h0);
    bus.stall = 1'b1;
    for (int i = 0; i < 18; i++) edge_sample();
    check("mid_init_addr17", 32'(bus.D_addr), 32'd17);
    #2 reset = 1'b1;
    #1;
    check("mid_init_rst_we", 32'(bus.we), 32'h0);
    check("mid_init_rst_addr", 32'(bus.D_addr), 32'h0);
    check("mid_init_rst_busy", 32'(bus.init_busy), 32'h1);
    @(negedge clk); reset = 1'b0;
    idle_inputs();
    check_clear_sequence("restart");

    // Table-driven RUN vectors.
    vecs.push_back('{"lb_lo0",  1,1,5'd3,2'b01,3'b000,2'd0,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'hFFFF_FF81});
    vecs.push_back('{"lbu_lo3", 1,1,5'd4,2'b01,3'b100,2'd3,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'h0000_0080});
    vecs.push_back('{"lh_lo2",  1,1,5'd6,2'b01,3'b001,2'd2,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'hFFFF_80F4});
    vecs.push_back('{"lhu_lo0", 1,1,5'd7,2'b01,3'b101,2'd0,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'h0000_7F81});
    vecs.push_back('{"lw",      1,1,5'd8,2'b01,3'b010,2'd0,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'h80F4_7F81});
    vecs.push_back('{"lb_lo1",  1,1,5'd9,2'b01,3'b000,2'd1,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'h0000_007F});
    vecs.push_back('{"lb_lo2",  1,1,5'd9,2'b01,3'b000,2'd2,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'hFFFF_FFF4});
    vecs.push_back('{"lhu_lo2", 1,1,5'd9,2'b01,3'b101,2'd2,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'h0000_80F4});
    vecs.push_back('{"lh_lo3",  1,1,5'd9,2'b01,3'b001,2'd3,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'hFFFF_80F4});
    vecs.push_back('{"f3_011",  1,1,5'd9,2'b01,3'b011,2'd1,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'h80F4_7F81});
    vecs.push_back('{"f3_110",  1,1,5'd9,2'b01,3'b110,2'd3,32'hAAAA_5555,32'h80F4_7F81,32'h0,1,32'h80F4_7F81});
    vecs.push_back('{"alu_rd5", 1,1,5'd5,2'b00,3'b000,2'd0,32'h1234_5678,32'h80F4_7F81,32'h0,1,32'h1234_5678});
    vecs.push_back('{"alu_rd0", 1,1,5'd0,2'b00,3'b000,2'd0,32'h1234_5678,32'h80F4_7F81,32'h0,0,32'h0});
    vecs.push_back('{"pc4_rd1", 1,1,5'd1,2'b10,3'b000,2'd0,32'h1234_5678,32'h80F4_7F81,32'h0000_0104,1,32'h0000_0104});
    vecs.push_back('{"sel11",   1,1,5'd2,2'b11,3'b000,2'd0,32'h1234_5678,32'h80F4_7F81,32'h0000_0104,1,32'h1234_5678});
    vecs.push_back('{"invalid", 0,1,5'd2,2'b00,3'b000,2'd0,32'h1234_5678,32'h0,32'h0,0,32'h0});
    vecs.push_back('{"no_rw",   1,0,5'd2,2'b00,3'b000,2'd0,32'h1234_5678,32'h0,32'h0,0,32'h0});

    @(negedge clk);
    foreach (vecs[i]) begin
      bus.mem_valid = vecs[i].valid; bus.mem_reg_write = vecs[i].reg_write;
      bus.mem_rd = vecs[i].rd; bus.mem_wb_sel = vecs[i].wb_sel;
      bus.mem_funct3 = vecs[i].funct3; bus.mem_addr_lo = vecs[i].addr_lo;
      bus.mem_alu_result = vecs[i].alu; bus.mem_load_data = vecs[i].load;
      bus.mem_pc_plus4 = vecs[i].pc4;
      edge_sample();
      check({vecs[i].name, "_we"}, 32'(bus.we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check({vecs[i].name, "_addr"}, 32'(bus.D_addr), 32'(vecs[i].rd));
        check({vecs[i].name, "_rin"}, bus.Rin, vecs[i].exp_rin);
      end
      @(negedge clk);
    end

    // Stall: bubbles with held port values, then the held instruction is captured.
    present(5'd4, 2'b00, 3'b000, 2'd0, 32'h0000_0444, 32'h0, 32'h0);
    edge_sample();
    held_addr = 5'd4; held_rin = 32'h0000_0444;
    @(negedge clk);
    present(5'd9, 2'b00, 3'b000, 2'd0, 32'h0000_0099, 32'h0, 32'h0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check("stall_we", 32'(bus.we), 32'h0);
      check("stall_hold_addr", 32'(bus.D_addr), 32'(held_addr));
      check("stall_hold_rin", bus.Rin, held_rin);
    end
    @(negedge clk); bus.stall = 1'b0;
    edge_sample();
    check("post_stall_we", 32'(bus.we), 32'h1);
    check("post_stall_addr", 32'(bus.D_addr), 32'd9);
    check("post_stall_rin", bus.Rin, 32'h0000_0099);
    @(negedge clk); bus.flush = 1'b1;
    edge_sample();
    check("flush_we", 32'(bus.we), 32'h0);
    @(negedge clk); bus.flush = 1'b1; bus.stall = 1'b1;
    edge_sample();
    check("stall_flush_we", 32'(bus.we), 32'h0);
    @(negedge clk); idle_inputs();

    // Back-to-back writes rd=1..31 then readback through both ports.
    for (int i = 1; i < 32; i++) begin
      present(5'(i), 2'b00, 3'b000, 2'd0, 32'(i), 32'h0, 32'h0);
      edge_sample();
      check("b2b_we", 32'(bus.we), 32'h1);
      check("b2b_addr", 32'(bus.D_addr), 32'(i));
      @(negedge clk);
    end
    idle_inputs();
    edge_sample();
    for (int a = 0; a < 31; a++) begin
      int b = 31 - a;
      check("read_A", rf[a], 32'(a));
      check("read_B", rf[b], 32'(b));
    end

    // Reset during RUN restarts the clear.
    @(negedge clk); reset = 1'b1;
    #1;
    check("run_rst_busy", 32'(bus.init_busy), 32'h1);
    check("run_rst_we", 32'(bus.we), 32'h0);
    @(negedge clk); reset = 1'b0;
    check_clear_sequence("run_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
